// File: rtl/fetch_if.sv
// Fetch unit bus: instruction-memory port, downstream handshake and debug control.
// FETCH_MISALIGN_CHK_EN adds misalign_o.
interface fetch_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        halt_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        halted_o;
  logic [1:0]  state_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  modport master (
`ifdef FETCH_MISALIGN_CHK_EN
    output misalign_o,
`endif
    output mem_addr,
    input  mem_instr,
    input  stall_i,
    input  redirect_i,
    input  redirect_pc_i,
    input  halt_i,
    output valid_o,
    output instr_o,
    output pc_o,
    output halted_o,
    output state_o
  );

  modport slave (
`ifdef FETCH_MISALIGN_CHK_EN
    input  misalign_o,
`endif
    input  mem_addr,
    output mem_instr,
    output stall_i,
    output redirect_i,
    output redirect_pc_i,
    output halt_i,
    input  valid_o,
    input  instr_o,
    input  pc_o,
    input  halted_o,
    input  state_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch with one-cycle memory, 1-entry skid buffer, redirect and debug halt.
// FETCH_MISALIGN_CHK_EN: misaligned redirects flush but keep pc_f and pulse misalign_o.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;

  // Handshake: an instruction is consumed when valid_o & !stall_i; while stall_i=1
  // instr_o/pc_o are held. redirect_i masks valid_o and flushes everything.
  state_e      state_q, state_d;
  logic [29:0] pc_f_q, pc_f_d;
  logic        inflight_v_q, inflight_v_d;
  logic [29:0] inflight_pc_q, inflight_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [29:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        halted_q, halted_d;
  logic        issue;
  logic        redir_load;
  logic [29:0] redir_word;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign redir_load = bus.redirect_i & ~|bus.redirect_pc_i[1:0];
  assign bus.misalign_o = misalign_q;
`else
  logic unused_redir_lo;
  assign redir_load      = bus.redirect_i;
  assign unused_redir_lo = ^bus.redirect_pc_i[1:0];
`endif
  assign redir_word = bus.redirect_pc_i[31:2];

  always_comb begin
    issue         = (state_q == RUN) & ~skid_v_q & ~bus.stall_i & ~bus.redirect_i;
    pc_f_d        = pc_f_q;
    inflight_v_d  = issue;
    inflight_pc_d = issue ? pc_f_q : inflight_pc_q;
    skid_v_d      = skid_v_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if (bus.redirect_i) begin
      if (redir_load) pc_f_d = redir_word;
      skid_v_d = 1'b0;
    end else begin
      if (issue) pc_f_d = pc_f_q + 30'd1;
      // The memory word arriving now would be lost under stall, so park it.
      if (inflight_v_q & bus.stall_i) begin
        skid_v_d     = 1'b1;
        skid_pc_d    = inflight_pc_q;
        skid_instr_d = bus.mem_instr;
      end else if (skid_v_q & ~bus.stall_i) begin
        skid_v_d = 1'b0;
      end
    end

    state_d = state_q;
    case (state_q)
      BOOT:    state_d = bus.halt_i ? HALT : RUN;
      RUN:     if (bus.halt_i) state_d = HALT;
      HALT:    if (!bus.halt_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
    halted_d = (state_d == HALT) & ~inflight_v_d & ~skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_f_q        <= RESET_PC[31:2];
      inflight_v_q  <= 1'b0;
      inflight_pc_q <= '0;
      skid_v_q      <= 1'b0;
      skid_pc_q     <= '0;
      skid_instr_q  <= '0;
      halted_q      <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_f_q        <= pc_f_d;
      inflight_v_q  <= inflight_v_d;
      inflight_pc_q <= inflight_pc_d;
      skid_v_q      <= skid_v_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      halted_q      <= halted_d;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q    <= bus.redirect_i & |bus.redirect_pc_i[1:0];
`endif
    end
  end

  assign bus.mem_addr = {2'b00, pc_f_q};
  assign bus.valid_o  = (skid_v_q | inflight_v_q) & ~bus.redirect_i & ~rst;
  assign bus.instr_o  = skid_v_q ? skid_instr_q : bus.mem_instr;
  assign bus.pc_o     = rst ? 32'h0 : (skid_v_q ? {skid_pc_q, 2'b00} : {inflight_pc_q, 2'b00});
  assign bus.halted_o = halted_q & ~rst;
  assign bus.state_o  = state_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 mem_addr  out  32  word index to instruction memory, {2'b00, pc_f[31:2]}; memory returns data one cycle later.
REQ-005 mem_instr  in  32  registered memory read data for the previous cycle's mem_addr.
REQ-006 stall_i  in  1  downstream cannot accept this cycle.
REQ-007 redirect_i  in  1  branch/jump redirect strobe.
REQ-008 redirect_pc_i  in  32  redirect target byte address.
REQ-009 halt_i  in  1  debug halt request; stops fetch while debug loads memory.
REQ-010 valid_o  out  1  instr_o/pc_o hold a valid instruction.
REQ-011 instr_o  out  32  fetched instruction.
REQ-012 pc_o  out  32  byte address of instr_o.
REQ-013 halted_o  out  1  state HALT, nothing in flight, skid empty.

Function
REQ-014 Registers: pc_f (next fetch PC), inflight_v/inflight_pc (request issued last cycle), skid_v/skid_pc/skid_instr (1-entry skid), state {BOOT, RUN, HALT}.
REQ-015 Issue occurs when state==RUN, !skid_v, !stall_i, !redirect_i; issue sets inflight_v=1, inflight_pc=pc_f, pc_f=pc_f+4 (32-bit wrap, 32'hFFFF_FFFC+4=0); otherwise inflight_v=0.
REQ-016 Outputs: valid_o = (skid_v | inflight_v) & !redirect_i & !rst; instr_o/pc_o = skid_v ? skid_instr/skid_pc : mem_instr/inflight_pc.
REQ-017 Handshake: instruction consumed when valid_o & !stall_i; held unchanged while stall_i=1.
REQ-018 inflight_v & stall_i & !redirect_i: mem_instr, inflight_pc captured into skid, skid_v=1.
REQ-019 skid_v & !stall_i & !redirect_i: skid_v=0 next cycle.
REQ-020 skid_v and inflight_v are never both 1.
REQ-021 Fetch latency: issue at cycle n -> valid_o at n+1; steady state one instruction per cycle.
REQ-022 redirect_i: pc_f=redirect_pc_i, inflight_v=0, skid_v=0, no issue that cycle; priority over stall_i and halt_i; first redirected instruction valid at n+2.
REQ-023 FSM: BOOT -> RUN (halt_i=0) or HALT (halt_i=1) after one cycle; RUN -> HALT when halt_i; HALT -> RUN when !halt_i.
REQ-024 HALT: no issue; existing inflight/skid entries drain per REQ-016..019; pc_f preserved (redirect still updates it); resume fetches from pc_f.

Reset
REQ-025 rst=1: state=BOOT, pc_f=RESET_PC, inflight_v=0, skid_v=0; valid_o=0, halted_o=0 during rst; pc_o=0, instr_o=mem_instr (don't-care).
REQ-026 rst mid-stall or mid-redirect discards all in-flight and skid contents; first fetch after release is RESET_PC.

Configuration
REQ-027 Macro FETCH_MISALIGN_CHK_EN adds port misalign_o (out, 1).
REQ-028 Defined: redirect with redirect_pc_i[1:0]!=0 flushes per REQ-022 but leaves pc_f unchanged and pulses misalign_o=1 for the next cycle only.
REQ-029 Not defined: no misalign_o port; redirect_pc_i[1:0] ignored, pc_f = {redirect_pc_i[31:2], 2'b00}.

Verification
REQ-030 Reset release, stall_i=0 -> mem_addr 0,1,2 on cycles 1,2,3; valid_o from cycle 2 with pc_o 0x0,0x4,0x8.
REQ-031 stall_i high 3 cycles while pc_o=0x8 -> instr_o/pc_o stable 0x8; next consumed instruction pc 0xC, none lost or duplicated.
REQ-032 redirect_i to 0x40 during stall -> valid_o=0 that cycle; next valid pc_o=0x40 two cycles later.
REQ-033 halt_i=1 in RUN -> issue stops, halted_o=1 after drain; halt_i=0 resumes at the next sequential pc.
REQ-034 With FETCH_MISALIGN_CHK_EN, redirect to 0x42 -> misalign_o pulse one cycle, pc_f unchanged; without macro fetch resumes at 0x40.
REQ-035 rst asserted with skid_v=1 -> valid_o=0 immediately; after release fetch restarts at RESET_PC.
